// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO of arbitrary depth with fill count, threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; leave it undefined for registered reads.
module fifo_sync_flags #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (32'(count_q) >= AF_THRESH);
  assign almost_empty = (32'(count_q) <= AE_THRESH);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap keeps non-power-of-two depths correct.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (!wr_acc && rd_acc) count_d = count_q - CW'(1);
    // A fresh error outranks a simultaneous clear.
    overflow_d  = (overflow_q && !clr_err) || (wr_en && full);
    underflow_d = (underflow_q && !clr_err) || (rd_en && empty);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem_q[rd_ptr_q];
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = rd_acc;
    if (rd_acc) data_out_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: DEPTH=5 and DEPTH=16 instances, read data checked through a scoreboard.
// Builds for either read mode depending on FIFO_FWFT_EN.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn5, wr5, rd5, clr5;
  logic [7:0] din5, dout5;
  logic       rv5, full5, empty5, af5, ae5, ov5, un5;
  logic [2:0] cnt5;

  logic       rstn16, wr16, rd16, clr16;
  logic [7:0] din16, dout16;
  logic       rv16, full16, empty16, af16, ae16, ov16, un16;
  logic [4:0] cnt16;

  fifo_sync_flags #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rstn(rstn5), .wr_en(wr5), .data_in(din5), .rd_en(rd5),
    .data_out(dout5), .rd_valid(rv5), .full(full5), .empty(empty5),
    .almost_full(af5), .almost_empty(ae5), .count(cnt5),
    .overflow(ov5), .underflow(un5), .clr_err(clr5)
  );

  fifo_sync_flags #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) u_dut16 (
    .clk(clk), .rstn(rstn16), .wr_en(wr16), .data_in(din16), .rd_en(rd16),
    .data_out(dout16), .rd_valid(rv16), .full(full16), .empty(empty16),
    .almost_full(af16), .almost_empty(ae16), .count(cnt16),
    .overflow(ov16), .underflow(un16), .clr_err(clr16)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         mcnt [2];
  logic [7:0] q5 [$];
  logic [7:0] q16 [$];

  // Scoreboard: a read result is visible mid-cycle (FWFT: head before the pop edge; registered: after it).
  always @(negedge clk) begin
    logic [7:0] exp;
`ifdef FIFO_FWFT_EN
    if (rstn5 && rd5 && rv5) begin
`else
    if (rv5) begin
`endif
      n_tests++;
      if (q5.size() == 0) begin
        n_fail++; $display("FAIL sb_extra5 got %0h required no read data", dout5);
      end else begin
        exp = q5.pop_front();
        if (dout5 !== exp) begin n_fail++; $display("FAIL sb_data5 got %0h required %0h", dout5, exp); end
      end
    end
`ifdef FIFO_FWFT_EN
    if (rstn16 && rd16 && rv16) begin
`else
    if (rv16) begin
`endif
      n_tests++;
      if (q16.size() == 0) begin
        n_fail++; $display("FAIL sb_extra16 got %0h required no read data", dout16);
      end else begin
        exp = q16.pop_front();
        if (dout16 !== exp) begin n_fail++; $display("FAIL sb_data16 got %0h required %0h", dout16, exp); end
      end
    end
  end

  // One clock of stimulus; the model predicts acceptance and queues accepted write data.
  task automatic step(input int sel, input logic w, input logic [7:0] d, input logic r, input logic c);
    int  dep;
    bit  wa, ra;
    dep = (sel == 0) ? 5 : 16;
    wa  = w && (mcnt[sel] < dep);
    ra  = r && (mcnt[sel] != 0);
    if (sel == 0) begin wr5 = w; din5 = d; rd5 = r; clr5 = c; end
    else          begin wr16 = w; din16 = d; rd16 = r; clr16 = c; end
    if (wa) begin
      if (sel == 0) q5.push_back(d); else q16.push_back(d);
    end
    if (wa && !ra)      mcnt[sel]++;
    else if (ra && !wa) mcnt[sel]--;
    @(posedge clk); #1;
    wr5 = 0; rd5 = 0; clr5 = 0; wr16 = 0; rd16 = 0; clr16 = 0;
  endtask

  task automatic test_reset();
    rstn5 = 0; rstn16 = 0; wr5 = 1; din5 = 8'hEE; rd5 = 0; clr5 = 0;
    wr16 = 0; din16 = 0; rd16 = 0; clr16 = 0;
    mcnt[0] = 0; mcnt[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (cnt5 !== 3'd0)  begin n_fail++; $display("FAIL rst_count got %0d required 0", cnt5); end
    n_tests++; if (empty5 !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b required 1", empty5); end
    n_tests++; if (full5 !== 1'b0)  begin n_fail++; $display("FAIL rst_full got %b required 0", full5); end
    n_tests++; if (ae5 !== 1'b1)    begin n_fail++; $display("FAIL rst_ae got %b required 1", ae5); end
    n_tests++; if (af5 !== 1'b0)    begin n_fail++; $display("FAIL rst_af got %b required 0", af5); end
    n_tests++; if (ov5 !== 1'b0 || un5 !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b%b required 00", ov5, un5); end
    n_tests++; if (rv5 !== 1'b0)    begin n_fail++; $display("FAIL rst_rvalid got %b required 0", rv5); end
`ifndef FIFO_FWFT_EN
    n_tests++; if (dout5 !== 8'h00) begin n_fail++; $display("FAIL rst_dout got %0h required 0", dout5); end
`endif
    n_tests++; if (cnt16 !== 5'd0 || empty16 !== 1'b1 || af16 !== 1'b0)
      begin n_fail++; $display("FAIL rst16 got cnt=%0d e=%b af=%b required 0 1 0", cnt16, empty16, af16); end
    wr5 = 0; rstn5 = 1; rstn16 = 1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 8'(i), 0, 0);
      n_tests++; if (cnt5 !== 3'(i)) begin n_fail++; $display("FAIL fill_count got %0d required %0d", cnt5, i); end
    end
    n_tests++; if (full5 !== 1'b1 || af5 !== 1'b1) begin n_fail++; $display("FAIL fill_full got full=%b af=%b required 1 1", full5, af5); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 1, 0);
      n_tests++; if (cnt5 !== 3'(4 - i)) begin n_fail++; $display("FAIL drain_count got %0d required %0d", cnt5, 4 - i); end
    end
    step(0, 0, 8'h00, 0, 0);
    n_tests++; if (empty5 !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b required 1", empty5); end
    n_tests++; if (q5.size() != 0) begin n_fail++; $display("FAIL drain_pending got %0d required 0", q5.size()); end
    n_tests++; if (rv5 !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid got %b required 0", rv5); end
`ifndef FIFO_FWFT_EN
    n_tests++; if (dout5 !== 8'h05) begin n_fail++; $display("FAIL hold_dout got %0h required 5", dout5); end
`endif
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h20 + 16 * r + i), 0, 0);
      n_tests++; if (cnt5 !== 3'd4) begin n_fail++; $display("FAIL wrap_count got %0d required 4", cnt5); end
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
      step(0, 0, 8'h00, 0, 0);
      n_tests++; if (q5.size() != 0 || cnt5 !== 3'd0)
        begin n_fail++; $display("FAIL wrap_drain got pending=%0d cnt=%0d required 0 0", q5.size(), cnt5); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'(8'h40 + i), 1, 0);
      n_tests++; if (cnt5 !== 3'd3) begin n_fail++; $display("FAIL simul_count got %0d required 3", cnt5); end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    n_tests++; if (q5.size() != 0 || empty5 !== 1'b1)
      begin n_fail++; $display("FAIL simul_drain got pending=%0d empty=%b required 0 1", q5.size(), empty5); end
  endtask

  task automatic test_boundary_full();
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h50 + i), 0, 0);
    step(0, 1, 8'hFF, 1, 0);
    n_tests++; if (cnt5 !== 3'd4) begin n_fail++; $display("FAIL bfull_count got %0d required 4", cnt5); end
    n_tests++; if (ov5 !== 1'b1 || un5 !== 1'b0) begin n_fail++; $display("FAIL bfull_err got ov=%b un=%b required 1 0", ov5, un5); end
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    n_tests++; if (q5.size() != 0 || empty5 !== 1'b1)
      begin n_fail++; $display("FAIL bfull_drain got pending=%0d empty=%b required 0 1", q5.size(), empty5); end
  endtask

  task automatic test_boundary_empty();
    step(0, 1, 8'hA5, 1, 0);
    n_tests++; if (cnt5 !== 3'd1) begin n_fail++; $display("FAIL bempty_count got %0d required 1", cnt5); end
    n_tests++; if (un5 !== 1'b1 || ov5 !== 1'b1) begin n_fail++; $display("FAIL bempty_err got un=%b ov=%b required 1 1", un5, ov5); end
`ifdef FIFO_FWFT_EN
    n_tests++; if (rv5 !== 1'b1 || dout5 !== 8'hA5) begin n_fail++; $display("FAIL bempty_head got v=%b d=%0h required 1 a5", rv5, dout5); end
`else
    n_tests++; if (rv5 !== 1'b0) begin n_fail++; $display("FAIL bempty_rvalid got %b required 0", rv5); end
`endif
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    n_tests++; if (q5.size() != 0 || cnt5 !== 3'd0)
      begin n_fail++; $display("FAIL bempty_drain got pending=%0d cnt=%0d required 0 0", q5.size(), cnt5); end
  endtask

  task automatic test_errors();
    step(0, 0, 8'h00, 0, 1);
    n_tests++; if (ov5 !== 1'b0 || un5 !== 1'b0) begin n_fail++; $display("FAIL clr_both got ov=%b un=%b required 0 0", ov5, un5); end
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0, 0);
    step(0, 1, 8'h99, 0, 1);
    n_tests++; if (ov5 !== 1'b1 || cnt5 !== 3'd5) begin n_fail++; $display("FAIL clr_vs_ovf got ov=%b cnt=%0d required 1 5", ov5, cnt5); end
    step(0, 0, 8'h00, 0, 0);
    n_tests++; if (ov5 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b required 1", ov5); end
    step(0, 0, 8'h00, 0, 1);
    n_tests++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b required 0", ov5); end
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 1);
    n_tests++; if (un5 !== 1'b1) begin n_fail++; $display("FAIL clr_vs_unf got %b required 1", un5); end
    step(0, 0, 8'h00, 0, 1);
    n_tests++; if (un5 !== 1'b0 || q5.size() != 0) begin n_fail++; $display("FAIL unf_clear got un=%b pending=%0d required 0 0", un5, q5.size()); end
  endtask

  task automatic test_thresholds();
    for (int k = 1; k <= 16; k++) begin
      step(1, 1, 8'(8'h80 + k), 0, 0);
      n_tests++;
      if (ae16 !== (k <= 2) || af16 !== (k >= 14) || full16 !== (k == 16) || cnt16 !== 5'(k)) begin
        n_fail++; $display("FAIL thr_fill k=%0d got ae=%b af=%b full=%b cnt=%0d", k, ae16, af16, full16, cnt16);
      end
    end
    for (int k = 15; k >= 0; k--) begin
      step(1, 0, 8'h00, 1, 0);
      n_tests++;
      if (ae16 !== (k <= 2) || af16 !== (k >= 14) || empty16 !== (k == 0) || cnt16 !== 5'(k)) begin
        n_fail++; $display("FAIL thr_drain k=%0d got ae=%b af=%b empty=%b cnt=%0d", k, ae16, af16, empty16, cnt16);
      end
    end
    step(1, 0, 8'h00, 0, 0);
    n_tests++; if (q16.size() != 0) begin n_fail++; $display("FAIL thr_pending got %0d required 0", q16.size()); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) step(1, 1, 8'(8'hC0 + i), 0, 0);
    n_tests++; if (cnt16 !== 5'd7) begin n_fail++; $display("FAIL mid_pre got %0d required 7", cnt16); end
    rstn16 = 0; wr16 = 1; din16 = 8'hDD;
    q16.delete(); mcnt[1] = 0;
    @(posedge clk); #1;
    wr16 = 0; rstn16 = 1;
    n_tests++; if (cnt16 !== 5'd0 || empty16 !== 1'b1 || rv16 !== 1'b0)
      begin n_fail++; $display("FAIL mid_rst got cnt=%0d e=%b v=%b required 0 1 0", cnt16, empty16, rv16); end
    step(1, 1, 8'h77, 0, 0);
`ifdef FIFO_FWFT_EN
    n_tests++; if (rv16 !== 1'b1 || dout16 !== 8'h77) begin n_fail++; $display("FAIL mid_head got v=%b d=%0h required 1 77", rv16, dout16); end
`else
    n_tests++; if (rv16 !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid got %b required 0", rv16); end
`endif
    step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 0, 0);
    n_tests++; if (q16.size() != 0 || cnt16 !== 5'd0)
      begin n_fail++; $display("FAIL mid_drain got pending=%0d cnt=%0d required 0 0", q16.size(), cnt16); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_boundary_full();
    test_boundary_empty();
    test_errors();
    test_thresholds();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
